// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Holds the fetch FSM state encoding, the self-loop halt opcode and default widths.
// Imported by the fetch interface, the fetch sequencer and the branch target adder.
package fetch_pkg;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // rjmp .-1 : a jump to itself, used by firmware as "stop here"
  localparam logic [15:0] HALT_OPCODE = 16'hCFFF;

  localparam int ADDR_WIDTH_D = 8;
  localparam int DATA_WIDTH_D = 16;
  localparam int OFF_WIDTH_D  = 12;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: ROM address/data, decode handshake and redirect request.
// master = fetch sequencer, slave = the ROM/decode/execute side.
// halted is included so observers see the stop condition with the stream.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int OFF_WIDTH  = OFF_WIDTH_D
);

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  branch_taken;
  logic [OFF_WIDTH-1:0]  branch_offset;
  logic                  halted;

  modport master (
    output rom_addr, instr, instr_pc, instr_valid, halted,
    input  rom_data, instr_ready, branch_taken, branch_offset
  );

  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid, halted,
    output rom_data, instr_ready, branch_taken, branch_offset
  );

endinterface

// File: rtl/pc_target_calc.sv
// Relative jump target: instr_pc + 1 + sign-extended offset, wrapped to the PC width.
// Purely combinational, zero latency.
// No handshake; shared with the call/return unit.
module pc_target_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int OFF_WIDTH  = OFF_WIDTH_D
) (
  input  logic [ADDR_WIDTH-1:0] instr_pc_i,
  input  logic [OFF_WIDTH-1:0]  offset_i,
  output logic [ADDR_WIDTH-1:0] target_o
);

  // Wide enough that neither operand loses bits before the final wrap.
  localparam int EXT_WIDTH = ADDR_WIDTH + OFF_WIDTH;

  logic [EXT_WIDTH-1:0] pc_ext;
  logic [EXT_WIDTH-1:0] off_ext;

  assign pc_ext  = {{OFF_WIDTH{1'b0}}, instr_pc_i};
  assign off_ext = {{ADDR_WIDTH{offset_i[OFF_WIDTH-1]}}, offset_i};

  // Two's-complement add; keeping only the low bits gives the modulo wrap.
  assign target_o = ADDR_WIDTH'(pc_ext + off_ext + EXT_WIDTH'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, drives the ROM address, presents one word per cycle to decode.
// Latency: rom_addr=A at cycle n -> instr_pc=A valid after posedge n+1; taken branch costs one bubble.
// Backpressure: instr/instr_pc/pc hold while valid && !ready; HALT_DETECT_EN adds self-loop halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_D,
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int OFF_WIDTH    = OFF_WIDTH_D,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  instr_valid_q;
  logic [ADDR_WIDTH-1:0] branch_pc_d;
  logic                  adv_d;
`ifdef HALT_DETECT_EN
  logic                  halted_q;
  logic                  halt_accept_d;
`endif

  // Target is relative to the branch instruction currently held for decode.
  pc_target_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OFF_WIDTH  (OFF_WIDTH)
  ) u_target (
    .instr_pc_i (instr_pc_q),
    .offset_i   (bus.branch_offset),
    .target_o   (branch_pc_d)
  );

  // Capture a new word whenever the output slot is empty or being drained.
  assign adv_d = !instr_valid_q || bus.instr_ready;

`ifdef HALT_DETECT_EN
  // The self-loop is handed to decode once; its acceptance stops fetch.
  assign halt_accept_d = instr_valid_q && bus.instr_ready &&
                         (instr_q == DATA_WIDTH'(HALT_OPCODE));
`endif

  // Fetch FSM: PRIME lets the ROM output register load the reset-vector word,
  // RUN streams/redirects, HALT freezes the PC until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PRIME;
      pc_q          <= ADDR_WIDTH'(RESET_VECTOR);
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef HALT_DETECT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        PRIME: state_q <= RUN;
        RUN: begin
`ifdef HALT_DETECT_EN
          if (halt_accept_d) begin
            state_q       <= HALT;
            pc_q          <= instr_pc_q;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else
`endif
          if (bus.branch_taken) begin
            // Squash wins over ready: decode already owns the branch itself.
            pc_q          <= branch_pc_d;
            instr_valid_q <= 1'b0;
          end else if (adv_d) begin
            instr_q       <= bus.rom_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + 1'b1;
          end
        end
        default: ; // HALT: everything frozen until reset
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
`ifdef HALT_DETECT_EN
  assign bus.halted      = halted_q;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a negedge-latching ROM model.
// Expected fetches are queued as stimulus is driven and popped when decode accepts.
// Halt checks are compiled in when HALT_DETECT_EN is defined.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] word;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [15:0] rom [256];

  fetch_sequencer_if bus_if ();

  fetch_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input int a);
    case (a)
      0:       return 16'hE005;
      1:       return 16'hE01F;
      2:       return 16'h930F;
      9:       return 16'hCFFA;
      31:      return 16'hCFFF;
      default: return 16'h1000 | 16'(a);
    endcase
  endfunction

  // ROM model: output register latches on the falling edge.
  always @(negedge clk) bus_if.rom_data = rom[bus_if.rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acceptance monitor: inputs are stable mid-cycle, so a valid&&ready seen at
  // the negedge is consumed at the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_if.instr_valid && bus_if.instr_ready) begin
      if (sb_q.size() == 0) begin
        check("accept_unexpected_pc", {24'd0, bus_if.instr_pc}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("accept_pc", {24'd0, bus_if.instr_pc}, {24'd0, e.pc});
        check("accept_word", {16'd0, bus_if.instr}, {16'd0, e.word});
      end
    end
  end

  task automatic push_exp(input int pc);
    exp_t e;
    e.pc   = 8'(pc);
    e.word = rom_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_live(input int pc, input int addr);
    check("live_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    check("live_pc", {24'd0, bus_if.instr_pc}, 32'(pc));
    check("live_instr", {16'd0, bus_if.instr}, {16'd0, rom_word(pc)});
    check("live_rom_addr", {24'd0, bus_if.rom_addr}, 32'(addr));
  endtask

  task automatic expect_bubble(input int addr);
    check("bubble_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    check("bubble_rom_addr", {24'd0, bus_if.rom_addr}, 32'(addr));
  endtask

  task automatic expect_reset();
    check("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    check("rst_instr", {16'd0, bus_if.instr}, 32'd0);
    check("rst_instr_pc", {24'd0, bus_if.instr_pc}, 32'd0);
    check("rst_rom_addr", {24'd0, bus_if.rom_addr}, 32'd0);
    check("rst_halted", {31'd0, bus_if.halted}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = rom_word(i);
    rst_n                = 1'b0;
    bus_if.instr_ready   = 1'b1;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_offset = 12'd0;

    step();
    step();
    expect_reset();
    rst_n = 1'b1;

    // Reset release and first fetches
    push_exp(0);
    push_exp(1);
    push_exp(2);
    step();
    check("prime_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    check("prime_rom_addr", {24'd0, bus_if.rom_addr}, 32'd0);
    step(); expect_live(0, 1);
    step(); expect_live(1, 2);
    step(); expect_live(2, 3);

    // Backpressure: hold instr_pc=2 for three edges
    bus_if.instr_ready = 1'b0;
    repeat (3) begin
      step();
      expect_live(2, 3);
    end
    bus_if.instr_ready = 1'b1;
    for (int p = 3; p <= 9; p++) push_exp(p);
    for (int p = 3; p <= 9; p++) begin
      step();
      expect_live(p, p + 1);
    end

    // Backward branch from 9 with k=-6 -> 4
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'hFFA;
    step();
    bus_if.branch_taken = 1'b0;
    expect_bubble(4);
    push_exp(4);
    push_exp(5);
    push_exp(6);
    step(); expect_live(4, 5);
    step(); expect_live(5, 6);
    step(); expect_live(6, 7);

    // Forward branch from 6 with k=+5 -> 12
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'd5;
    step();
    bus_if.branch_taken = 1'b0;
    expect_bubble(12);
    step(); expect_live(12, 13);

    // Branch while decode stalls: squash and redirect 12-1 -> 11
    bus_if.instr_ready   = 1'b0;
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'hFFE;
    step();
    bus_if.branch_taken = 1'b0;
    bus_if.instr_ready  = 1'b1;
    expect_bubble(11);
    push_exp(11);
    step(); expect_live(11, 12);

    // Jump to 255 and wrap to 0
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'd243;
    step();
    bus_if.branch_taken = 1'b0;
    expect_bubble(255);
    push_exp(255);
    push_exp(0);
    push_exp(1);
    step(); expect_live(255, 0);
    step(); expect_live(0, 1);
    step(); expect_live(1, 2);

    // Backward wrap: 1 + 1 - 4 -> 254
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'hFFC;
    step();
    bus_if.branch_taken = 1'b0;
    expect_bubble(254);
    step(); expect_live(254, 255);

    // Reset mid-stall drops outputs without a clock edge
    bus_if.instr_ready = 1'b0;
    step(); expect_live(254, 255);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    step();
    rst_n = 1'b1;
    bus_if.instr_ready = 1'b1;

    // Reach the self-loop word at 31
    push_exp(0);
    step();
    check("prime2_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    step(); expect_live(0, 1);
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'd30;
    step();
    bus_if.branch_taken = 1'b0;
    expect_bubble(31);
    push_exp(31);
    step(); expect_live(31, 32);

`ifdef HALT_DETECT_EN
    for (int c = 0; c < 12; c++) begin
      step();
      check("halt_halted", {31'd0, bus_if.halted}, 32'd1);
      check("halt_rom_addr", {24'd0, bus_if.rom_addr}, 32'd31);
      check("halt_valid", {31'd0, bus_if.instr_valid}, 32'd0);
      bus_if.branch_taken  = (c == 4);
      bus_if.branch_offset = 12'd5;
    end
`else
    step();
    bus_if.instr_ready = 1'b0;
    expect_live(32, 33);
    check("nohalt_halted", {31'd0, bus_if.halted}, 32'd0);
    // Execute of the self-loop: 32 + 1 - 2 -> 31 again
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_offset = 12'hFFE;
    step();
    bus_if.branch_taken = 1'b0;
    expect_bubble(31);
    check("nohalt_halted2", {31'd0, bus_if.halted}, 32'd0);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
